// File: rtl/cache_wr_sequencer.sv
// cache_wr_sequencer: steers USB3 read words into a two-page (2 x 128 word)
// cache RAM. Each burst starts with an optional header word that selects
// pack_type; the burst body is written to the current page and the page is
// closed (pkt_valid) when the burst ends or the page fills. Full pages are
// handed back by the reader through rd_release.
// Optional feature: define CACHE_WR_STATS_EN to add the drop_count output.
//
// Handshake: a word is offered when usb_rd_state == 6 (rd_active) and is
// always accepted that cycle; there is no back-pressure. Words that find no
// free page are dropped and flagged through the sticky overflow bit.
module cache_wr_sequencer (
    input  logic        wrclock,
    input  logic        rst_n,
    input  logic [3:0]  usb_rd_state,
    input  logic [31:0] data,
    input  logic        rd_release,
    input  logic        rd_page,
    output logic        wren,
    output logic [7:0]  wraddress,
    output logic [31:0] wrdata,
    output logic        pkt_valid,
    output logic        pkt_page,
    output logic [7:0]  pkt_len,
    output logic [3:0]  pack_type,
    output logic [1:0]  page_full,
    output logic        overflow,
`ifdef CACHE_WR_STATS_EN
    output logic [15:0] drop_count,
`endif
    output logic [2:0]  dbg_state
);

    // HDR is never held for a cycle: header evaluation happens in the IDLE
    // cycle that sees the first word. The encoding is kept so dbg_state
    // values stay stable for anything decoding them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        BURST = 3'd2,
        DROP  = 3'd3,
        CLOSE = 3'd4
    } state_t;

    state_t      state;
    logic        cur;
    logic [7:0]  offset;
    logic [3:0]  cur_type;

    logic        rd_active;
    logic        hdr_match;
    logic [3:0]  hdr_type;
    logic        full_close;
    logic        close_now;
    logic        drop_now;
    logic [1:0]  set_mask;
    logic [1:0]  rel_mask;

    assign dbg_state = state;

    // Decode the incoming word and the page bookkeeping events of this cycle.
    always_comb begin
        rd_active  = (usb_rd_state == 4'd6);
        hdr_match  = ((data & 32'hFF0000FF) == 32'hFF0000FF);
        case (data[23:8])
            16'h0000: hdr_type = 4'd1;
            16'h000A: hdr_type = 4'd2;
            16'h0014: hdr_type = 4'd3;
            default:  hdr_type = 4'hF;
        endcase
        full_close = (state == BURST) && rd_active && (offset == 8'd127);
        close_now  = (state == CLOSE) || full_close;
        drop_now   = rd_active &&
                     (((state == IDLE) && page_full[cur]) || (state == DROP));
        set_mask   = 2'b00;
        if (close_now) set_mask = cur ? 2'b10 : 2'b01;
        rel_mask   = 2'b00;
        if (rd_release) rel_mask = rd_page ? 2'b10 : 2'b01;
    end

    // Sequencer FSM with registered RAM write port and packet descriptor.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= 1'b0;
            offset    <= 8'd0;
            cur_type  <= 4'd0;
            wren      <= 1'b0;
            wraddress <= 8'd0;
            wrdata    <= 32'd0;
            pkt_valid <= 1'b0;
            pkt_page  <= 1'b0;
            pkt_len   <= 8'd0;
            pack_type <= 4'd0;
            page_full <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            wren      <= 1'b0;
            pkt_valid <= 1'b0;
            // A set and a release of the same page collide: set wins.
            page_full <= (page_full & ~rel_mask) | set_mask;
            if (drop_now) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (rd_active) begin
                        if (page_full[cur]) begin
                            state <= DROP;
                        end else begin
                            state <= BURST;
                            if (hdr_match) begin
                                cur_type <= hdr_type;
                                offset   <= 8'd0;
                            end else begin
                                // No header: the word is payload at offset 0.
                                cur_type  <= 4'hE;
                                wren      <= 1'b1;
                                wraddress <= {cur, 7'd0};
                                wrdata    <= data;
                                offset    <= 8'd1;
                            end
                        end
                    end
                end
                BURST: begin
                    if (rd_active) begin
                        wren      <= 1'b1;
                        wraddress <= {cur, offset[6:0]};
                        wrdata    <= data;
                        // Page just filled: any further words of this burst
                        // are discarded in DROP until rd_active falls.
                        if (full_close) state <= DROP;
                        else            offset <= offset + 8'd1;
                    end else begin
                        state <= CLOSE;
                    end
                end
                DROP: begin
                    if (!rd_active) state <= IDLE;
                end
                CLOSE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (close_now) begin
                pkt_valid <= 1'b1;
                pkt_page  <= cur;
                pkt_len   <= full_close ? 8'd128 : offset;
                pack_type <= cur_type;
                cur       <= ~cur;
                offset    <= 8'd0;
            end
        end
    end

`ifdef CACHE_WR_STATS_EN
    // Saturating count of words discarded for lack of a free page.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 16'd0;
        end else if (drop_now && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_wr_sequencer.sv
// Directed bench for cache_wr_sequencer: header/no-header packets, page fill
// with overflow, both-pages-full drop, release collisions, and mid-burst reset.
module tb_cache_wr_sequencer;

    logic        wrclock = 1'b0;
    logic        rst_n;
    logic [3:0]  usb_rd_state;
    logic [31:0] data;
    logic        rd_release;
    logic        rd_page;
    logic        wren;
    logic [7:0]  wraddress;
    logic [31:0] wrdata;
    logic        pkt_valid;
    logic        pkt_page;
    logic [7:0]  pkt_len;
    logic [3:0]  pack_type;
    logic [1:0]  page_full;
    logic        overflow;
    logic [2:0]  dbg_state;
`ifdef CACHE_WR_STATS_EN
    logic [15:0] drop_count;
`endif

    cache_wr_sequencer dut (
        .wrclock      (wrclock),
        .rst_n        (rst_n),
        .usb_rd_state (usb_rd_state),
        .data         (data),
        .rd_release   (rd_release),
        .rd_page      (rd_page),
        .wren         (wren),
        .wraddress    (wraddress),
        .wrdata       (wrdata),
        .pkt_valid    (pkt_valid),
        .pkt_page     (pkt_page),
        .pkt_len      (pkt_len),
        .pack_type    (pack_type),
        .page_full    (page_full),
        .overflow     (overflow),
`ifdef CACHE_WR_STATS_EN
        .drop_count   (drop_count),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 wrclock = ~wrclock;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pv_count = 0;
    logic        cap_page = 1'b0;
    logic [7:0]  cap_len  = 8'd0;
    logic [3:0]  cap_type = 4'd0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [7:0] addr, input logic [31:0] d);
        exp_q.push_back({addr, d});
    endtask

    // One clock: drive inputs, let the edge happen, then check the write port
    // against the expected queue and capture any packet descriptor.
    task automatic step(input logic [3:0] st, input logic [31:0] d,
                        input logic rel, input logic rp);
        logic [39:0] e;
        usb_rd_state = st;
        data         = d;
        rd_release   = rel;
        rd_page      = rp;
        @(posedge wrclock);
        #1;
        check("wren", {39'd0, wren}, {39'd0, (exp_q.size() != 0)});
        if (wren && (exp_q.size() != 0)) begin
            e = exp_q.pop_front();
            check("write", {wraddress, wrdata}, e);
        end
        if (pkt_valid) begin
            pv_count++;
            cap_page = pkt_page;
            cap_len  = pkt_len;
            cap_type = pack_type;
        end
        rd_release = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_pkt(input string tag, input int pv, input logic pg,
                             input logic [7:0] len, input logic [3:0] ty);
        check({tag, "_pv_count"}, 40'(pv_count), 40'(pv));
        check({tag, "_pkt_page"}, {39'd0, cap_page}, {39'd0, pg});
        check({tag, "_pkt_len"},  {32'd0, cap_len},  {32'd0, len});
        check({tag, "_pack_type"}, {36'd0, cap_type}, {36'd0, ty});
        check({tag, "_queue_empty"}, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic check_flags(input string tag, input logic [1:0] pf, input logic ov);
        check({tag, "_page_full"}, {38'd0, page_full}, {38'd0, pf});
        check({tag, "_overflow"},  {39'd0, overflow},  {39'd0, ov});
    endtask

    task automatic check_drops(input string tag, input logic [15:0] n);
`ifdef CACHE_WR_STATS_EN
        check({tag, "_drop_count"}, {24'd0, drop_count}, {24'd0, n});
`else
        if (n == 16'hFFFF) $display("drop_count check skipped for %s", tag);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"},      {39'd0, wren},      40'd0);
        check({tag, "_wraddress"}, {32'd0, wraddress}, 40'd0);
        check({tag, "_wrdata"},    {8'd0, wrdata},     40'd0);
        check({tag, "_pkt_valid"}, {39'd0, pkt_valid}, 40'd0);
        check({tag, "_pkt_page"},  {39'd0, pkt_page},  40'd0);
        check({tag, "_pkt_len"},   {32'd0, pkt_len},   40'd0);
        check({tag, "_pack_type"}, {36'd0, pack_type}, 40'd0);
        check({tag, "_state"},     {37'd0, dbg_state}, 40'd0);
        check_flags(tag, 2'b00, 1'b0);
        check_drops(tag, 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] w;
        rst_n        = 1'b0;
        usb_rd_state = 4'd0;
        data         = 32'd0;
        rd_release   = 1'b0;
        rd_page      = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge wrclock);
        @(posedge wrclock);
        #1;
        rst_n = 1'b1;
        idle(2);

        // A: header type 1, 10 words into page 0.
        step(4'd6, 32'hFF0000FF, 1'b0, 1'b0);
        check("A_state_burst", {37'd0, dbg_state}, 40'd2);
        for (int i = 0; i < 10; i++) begin
            w = 32'hA000_0000 + 32'(i);
            expect_write(8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        idle(3);
        check_pkt("A", 1, 1'b0, 8'd10, 4'd1);
        check_flags("A", 2'b01, 1'b0);

        // B: header type 2, 130 words into page 1; last two are dropped.
        step(4'd6, 32'hFF000AFF, 1'b0, 1'b0);
        for (int i = 0; i < 130; i++) begin
            w = 32'hB000_0000 + 32'(i);
            if (i < 128) expect_write(8'h80 + 8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        idle(2);
        check_pkt("B", 2, 1'b1, 8'd128, 4'd2);
        check_flags("B", 2'b11, 1'b1);
        check_drops("B", 16'd2);

        // C: both pages full, 5-word burst is dropped; then release page 0.
        for (int i = 0; i < 5; i++) step(4'd6, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        idle(1);
        check("C_pv_count", 40'(pv_count), 40'd2);
        check_drops("C", 16'd7);
        step(4'd0, 32'd0, 1'b1, 1'b0);
        check_flags("C_rel", 2'b10, 1'b1);

        // D: no header, first word is payload at offset 0, into page 0.
        expect_write(8'h00, 32'h1234_5678);
        step(4'd6, 32'h1234_5678, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            w = 32'hD000_0000 + 32'(i);
            expect_write(8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        idle(3);
        check_pkt("D", 3, 1'b0, 8'd4, 4'hE);
        check_flags("D", 2'b11, 1'b1);

        // E: release page 1, then a header-only packet (type 3) closes with len 0.
        step(4'd0, 32'd0, 1'b1, 1'b1);
        check_flags("E_rel", 2'b01, 1'b1);
        step(4'd6, 32'hFF0014FF, 1'b0, 1'b0);
        idle(3);
        check_pkt("E", 4, 1'b1, 8'd0, 4'd3);
        check_flags("E", 2'b11, 1'b1);

        // F: release page 0; unknown header type; release page 1 as page 0 closes.
        step(4'd0, 32'd0, 1'b1, 1'b0);
        check_flags("F_rel", 2'b10, 1'b1);
        step(4'd6, 32'hFF00FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w = 32'hF000_0000 + 32'(i);
            expect_write(8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        step(4'd0, 32'd0, 1'b0, 1'b0);
        step(4'd0, 32'd0, 1'b1, 1'b1);
        check_pkt("F", 5, 1'b0, 8'd2, 4'hF);
        check_flags("F", 2'b01, 1'b1);

        // G: header-only packet into page 1 closes while page 1 is released: set wins.
        step(4'd6, 32'hFF0000FF, 1'b0, 1'b0);
        step(4'd0, 32'd0, 1'b0, 1'b0);
        step(4'd0, 32'd0, 1'b1, 1'b1);
        check_pkt("G", 6, 1'b1, 8'd0, 4'd1);
        check_flags("G", 2'b11, 1'b1);

        // R: release page 0, start a burst, assert reset during word 6.
        step(4'd0, 32'd0, 1'b1, 1'b0);
        step(4'd6, 32'hFF0000FF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = 32'h5000_0000 + 32'(i);
            expect_write(8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        usb_rd_state = 4'd6;
        data         = 32'h5000_0005;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        usb_rd_state = 4'd0;
        @(posedge wrclock);
        #1;
        rst_n = 1'b1;
        idle(3);
        check("R_no_pkt_valid", 40'(pv_count), 40'd6);

        // H: after reset a header burst lands in page 0.
        step(4'd6, 32'hFF000AFF, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            w = 32'h6000_0000 + 32'(i);
            expect_write(8'(i), w);
            step(4'd6, w, 1'b0, 1'b0);
        end
        idle(3);
        check_pkt("H", 7, 1'b0, 8'd2, 4'd2);
        check_flags("H", 2'b01, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_wr_sequencer.md
CACHE_WR_SEQUENCER -- requirements
Module: cache_wr_sequencer

Interface
REQ-001 SHALL have: wrclock  in  1  write-side clock; all logic on its rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: usb_rd_state  in  4  USB3 read FSM state; value 4'd6 means "word valid on data this cycle" (rd_active).
REQ-004 SHALL have: data  in  32  USB3 word.
REQ-005 SHALL have: rd_release  in  1  one-cycle pulse, wrclock domain: reader has consumed page rd_page.
REQ-006 SHALL have: rd_page  in  1  page index qualified by rd_release.
REQ-007 SHALL have: wren  out  1  cache RAM write enable.
REQ-008 SHALL have: wraddress  out  8  cache RAM address; bit 7 = page, bits 6:0 = offset.
REQ-009 SHALL have: wrdata  out  32  cache RAM write data, aligned with wren.
REQ-010 SHALL have: pkt_valid  out  1  one-cycle pulse: packet closed in pkt_page.
REQ-011 SHALL have: pkt_page  out  1;  pkt_len  out  8 (words written, 0..128);  pack_type  out  4.
REQ-012 SHALL have: page_full  out  2  per-page full flags;  overflow  out  1  sticky drop flag.

Function
REQ-013 SHALL treat the 256-word cache as two 128-word pages, filled alternately starting at page 0.
REQ-014 SHALL implement states IDLE, HDR, BURST, DROP, CLOSE.
REQ-015 IDLE: on rd_active, if page_full[cur] = 1, go DROP, set overflow; else evaluate the current word as header (HDR action) in that same cycle, then go BURST.
REQ-016 Header match: (data & 32'hFF0000FF) == 32'hFF0000FF; type field data[23:8]: 16'h0000 -> pack_type 4'd1 (C/A code), 16'h000A -> 4'd2, 16'h0014 -> 4'd3, any other -> 4'hF.
REQ-017 A matched header word SHALL NOT be written; an unmatched first word SHALL set pack_type 4'hE and be written at offset 0.
REQ-018 BURST: each rd_active cycle writes data at {cur, offset}, offset increments; offset wraps never, page limit is 128 words.
REQ-019 Write latency: wren, wraddress, wrdata registered, one cycle after the qualifying rd_active/data.
REQ-020 BURST, rd_active low: go CLOSE. BURST, 128th word written: set page_full[cur], pulse pkt_valid (pkt_len 128), toggle cur, go DROP if rd_active still high next cycle, else IDLE.
REQ-021 CLOSE: set page_full[cur], pulse pkt_valid with pkt_page = cur, pkt_len = words written; toggle cur; go IDLE; zero-length bursts (header only) SHALL still close with pkt_len 0.
REQ-022 DROP: wren = 0; each rd_active word counts as dropped and sets overflow; rd_active low -> IDLE.
REQ-023 rd_release SHALL clear page_full[rd_page]; release of a non-full page is ignored; release and set of different pages in one cycle both take effect; release and set of the same page in one cycle: set wins.
REQ-024 overflow SHALL stay set until reset.
REQ-025 pack_type, pkt_page, pkt_len SHALL hold their values until the next pkt_valid.

Reset
REQ-026 rst_n low SHALL force immediately: state IDLE, cur 0, offset 0, wren 0, wraddress 0, wrdata 0, pkt_valid 0, pkt_page 0, pkt_len 0, pack_type 0, page_full 2'b00, overflow 0.
REQ-027 Reset mid-burst SHALL abandon the packet without pkt_valid; after release the next rd_active starts a new header at page 0.

Configuration
REQ-028 With CACHE_WR_STATS_EN defined: extra output drop_count  out  16, counts dropped words, saturates at 16'hFFFF, reset 0.
REQ-029 Without CACHE_WR_STATS_EN: no drop_count port or counter; all other behaviour identical.

Verification
REQ-030 Header FF0000FF then 10 words, rd_active drops -> 10 writes at 0x00..0x09, pkt_valid, pkt_page 0, pkt_len 10, pack_type 1, page_full 2'b01.
REQ-031 Header FF000AFF then 130 words -> 128 writes 0x80..0xFF after first page, pkt_len 128, pack_type 2, 2 words dropped, overflow 1, drop_count 2 (macro on).
REQ-032 First word 12345678 (no header) plus 3 words -> 4 writes from offset 0, pack_type 4'hE, pkt_len 4.
REQ-033 Both pages full, new burst of 5 words -> no wren, overflow 1, drop_count 5; rd_release rd_page 0 -> page_full 2'b10, next burst writes page 0.
REQ-034 rst_n low during word 6 of a burst -> all outputs at reset values immediately, no pkt_valid; next burst header-parsed into page 0.
REQ-035 rd_release of page 1 in the same cycle page 0 closes -> page_full 2'b01 afterwards.
